my_fifo8x16: RTL and testbench
==============================

// Module: my_fifo8x16
// PURPOSE
//   Eight-entry, 16-bit synchronous FIFO with valid/ready on both sides.
//   Storage is eight 16-bit registers. The read port is one my_mux8way16
//   selected by the 3-bit read pointer.
//   It buffers words between a producer and a consumer in the gate-level CPU
//   datapath, for example ALU results queued for the memory write-back stage.
// PARAMETERS
//   AFULL_LVL  6  almost_full asserts when count >= AFULL_LVL; legal range 1..8
//   (Depth is fixed at 8 and width at 16 by the 8-way/16-bit read mux.)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   reset        in   1   synchronous, active-high reset
//   flush        in   1   synchronous clear of FIFO occupancy
//   in_data      in   16  write word (shortint)
//   in_valid     in   1   producer has a word on in_data
//   in_ready     out  1   FIFO can accept a word this cycle
//   out_data     out  16  head word (shortint)
//   out_valid    out  1   head word present
//   out_ready    in   1   consumer takes the head word this cycle
//   count        out  4   occupancy, 0..8
//   almost_full  out  1   count >= AFULL_LVL
// BEHAVIOUR
//   - State: mem[0:7] (16 b each), wr_ptr[2:0], rd_ptr[2:0], count[3:0].
//   - reset=1 at a clock edge: wr_ptr=rd_ptr=0, count=0, all mem words=0.
//     reset overrides flush, push and pop in the same cycle.
//     Outputs after reset: in_ready=1, out_valid=0, out_data=0, count=0,
//     almost_full=0.
//   - Combinational outputs:
//       in_ready    = (count != 8)
//       out_valid   = (count != 0)
//       out_data    = out_valid ? mem[rd_ptr] : 16'h0000
//       almost_full = (count >= AFULL_LVL)
//   - push = in_valid & in_ready. pop = out_valid & out_ready.
//   - On push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1.
//   - On pop: rd_ptr <= rd_ptr+1.
//   - Pointers are 3 bits and wrap 7 -> 0 naturally.
//   - Count update:
//       push & !pop : count+1
//       pop & !push : count-1
//       push & pop  : unchanged
//   - Simultaneous push and pop is legal only when 0 < count < 8.
//     - Empty: pop is impossible, so push alone occurs and count -> 1.
//     - Full: in_ready=0, so a pop alone occurs and count -> 7.
//       No pass-through write into a full FIFO.
//   - Latency: a word pushed at edge N appears on out_data, with
//     out_valid=1, after edge N (one cycle). There is no bypass while empty.
//   - Ordering is strictly first-in first-out. Words are never dropped or
//     duplicated.
//   - in_valid while full: the word is not taken. The producer holds it.
//   - out_ready while empty: ignored; no state change.
//   - flush=1 (and reset=0): wr_ptr=rd_ptr=0, count=0. mem is unchanged.
//     flush has priority over push and pop in the same cycle.
//   - Reset or flush mid-stream discards all buffered words. The next push
//     writes mem[0].
// TESTING
//   1. Reset, then push 16'h1111..16'h8888 on 8 consecutive cycles
//      -> count 1..8; almost_full=1 from count=6; in_ready=0 at count=8.
//   2. From full, hold in_valid=1 with 16'h9999 and pop all 8
//      -> out_data 1111..8888 in order. The first pop cycle does not accept
//      9999; it is accepted on the next cycle. Count ends at 1, head=9999.
//   3. Count=3 with head 16'hA000; push 16'hB000 and pop in the same cycle
//      -> count stays 3; new head is the second entry; B000 is appended last.
//   4. Wrap: push 5, pop 5, then push 16'h0001..16'h0006
//      -> wr_ptr passes 7 -> 0. The pop order is 0001..0006 and count
//      returns to 0.
//   5. Count=5, assert flush together with in_valid=1 and out_ready=1
//      -> next cycle count=0, out_valid=0, out_data=0, in_ready=1; nothing
//      stored or popped.
//   6. Count=4, assert reset together with push/pop/flush
//      -> count=0, out_data=0; a following push of 16'hCAFE appears on
//      out_data one cycle later.

Source files
------------

// File: rtl/my_fifo8x16.sv
// Eight-entry, 16-bit synchronous FIFO with valid/ready handshakes on both sides.
// Storage is eight registers; the head word is selected by an 8-way 16-bit mux on rd_ptr.

module my_mux8way16 (
   input  logic [7:0][15:0] d_in,
   input  logic [2:0]       sel,
   output logic [15:0]      d_out
);
   assign d_out = d_in[sel];
endmodule

module my_fifo8x16 #(
   parameter int AFULL_LVL = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  count,
   output logic        almost_full
);
   logic [15:0]       mem_q [8];
   logic [15:0]       mem_d [8];
   logic [2:0]        wr_ptr_q, wr_ptr_d;
   logic [2:0]        rd_ptr_q, rd_ptr_d;
   logic [3:0]        count_q, count_d;
   logic              push, pop;
   logic [7:0][15:0]  mem_bus;
   logic [15:0]       head;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bus
         assign mem_bus[gi] = mem_q[gi];
      end
   endgenerate

   my_mux8way16 u_rd_mux (
      .d_in  (mem_bus),
      .sel   (rd_ptr_q),
      .d_out (head)
   );

   assign in_ready    = (count_q != 4'd8);
   assign out_valid   = (count_q != 4'd0);
   assign out_data    = out_valid ? head : 16'h0000;
   assign almost_full = (count_q >= 4'(AFULL_LVL));
   assign count       = count_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Flush only clears occupancy; stale words stay in mem but are unreachable.
      if (flush) begin
         wr_ptr_d = 3'd0;
         rd_ptr_d = 3'd0;
         count_d  = 4'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 3'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
         end
         if (push && !pop) begin
            count_d = count_q + 4'd1;
         end else if (pop && !push) begin
            count_d = count_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: 16'h0000};
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         count_q  <= 4'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: tb/tb_my_fifo8x16.sv
// Bench for my_fifo8x16: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of FIFO occupancy and ordering.

module tb_my_fifo8x16;
   localparam int AFULL = 6;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid, almost_full;
   logic [15:0] out_data;
   logic [3:0]  count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] q [$];
   logic        last_push;
   logic        pending;

   my_fifo8x16 #(.AFULL_LVL(AFULL)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare all outputs to the model, apply one clock, then advance the model.
   task automatic cycle(input logic r, input logic f, input logic iv,
                        input logic [15:0] d, input logic rdy, input string tag);
      int          sz;
      logic        do_push, do_pop;
      logic [15:0] exp_head;
      sz       = q.size();
      exp_head = (sz != 0) ? q[0] : 16'h0000;
      reset = r; flush = f; in_valid = iv; in_data = d; out_ready = rdy;
      chk({tag, ".count"},       16'(count),       16'(sz));
      chk({tag, ".out_valid"},   16'(out_valid),   16'(sz != 0));
      chk({tag, ".out_data"},    out_data,         exp_head);
      chk({tag, ".in_ready"},    16'(in_ready),    16'(sz < 8));
      chk({tag, ".almost_full"}, 16'(almost_full), 16'(sz >= AFULL));
      do_push = iv && (sz < 8);
      do_pop  = rdy && (sz > 0);
      $display("[TB] %s r=%0b f=%0b iv=%0b d=%h rdy=%0b count=%0d head=%h",
               tag, r, f, iv, d, rdy, count, out_data);
      @(posedge clk);
      last_push = 1'b0;
      if (r || f) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) begin
            q.push_back(d);
            last_push = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_check(input string tag);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, tag);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      @(posedge clk);
      @(negedge clk);
      q.delete();

      // 1: fill to full
      for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 16'(16'h1111 * i), 0, "t1_fill");
      chk("t1_full_in_ready", 16'(in_ready), 16'h0000);
      chk("t1_full_afull",    16'(almost_full), 16'h0001);
      chk("t1_full_count",    16'(count), 16'h0008);

      // 2: drain while producer holds 9999
      pending = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, pending, 16'h9999, 1, "t2_drain");
         if (last_push) pending = 1'b0;
      end
      chk("t2_end_count", 16'(count), 16'h0001);
      chk("t2_end_head",  out_data,   16'h9999);

      // 3: simultaneous push/pop at count 3
      cycle(0, 1, 0, 16'h0, 0, "t3_flush");
      cycle(0, 0, 1, 16'hA000, 0, "t3_fill");
      cycle(0, 0, 1, 16'hA001, 0, "t3_fill");
      cycle(0, 0, 1, 16'hA002, 0, "t3_fill");
      cycle(0, 0, 1, 16'hB000, 1, "t3_pushpop");
      chk("t3_count", 16'(count), 16'h0003);
      chk("t3_head",  out_data,   16'hA001);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 16'h0, 1, "t3_drain");

      // 4: pointer wrap
      cycle(0, 1, 0, 16'h0, 0, "t4_flush");
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'($urandom), 0, "t4_push5");
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 16'h0, 1, "t4_pop5");
      for (int i = 1; i <= 6; i++) cycle(0, 0, 1, 16'(i), 0, "t4_wrap_push");
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 16'h0, 1, "t4_wrap_pop");
      chk("t4_empty_count", 16'(count), 16'h0000);

      // 5: flush beats push and pop
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'($urandom), 0, "t5_fill");
      cycle(0, 1, 1, 16'h5555, 1, "t5_flush");
      chk("t5_count",     16'(count),     16'h0000);
      chk("t5_out_valid", 16'(out_valid), 16'h0000);
      chk("t5_out_data",  out_data,       16'h0000);
      chk("t5_in_ready",  16'(in_ready),  16'h0001);

      // 6: reset beats everything
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 16'($urandom), 0, "t6_fill");
      cycle(1, 1, 1, 16'h7777, 1, "t6_reset");
      chk("t6_count",    16'(count), 16'h0000);
      chk("t6_out_data", out_data,   16'h0000);
      cycle(0, 0, 1, 16'hCAFE, 0, "t6_push");
      chk("t6_cafe", out_data, 16'hCAFE);
      idle_check("t6_idle");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
               1'($urandom), 16'($urandom), 1'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
